if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the PipelineCPU, directly upstream of the ID stage. Owns the PC and issues one instruction-memory request at a time. Latches returned instructions into the IF/ID pipeline register. Honours ID-stage stall, EX-stage branch/jump redirect, and syscall-exit halt.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset (MARS text-segment base).
ADDR_W, 32, PC/address width.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
imem_req  out  1  request strobe, one-cycle pulse per fetch.
imem_addr  out  ADDR_W  fetch address, valid while imem_req=1.
imem_rvalid  in  1  response valid, exactly one per request, latency >= 1 cycle.
imem_rdata  in  32  instruction word, valid with imem_rvalid.
stall_i  in  1  ID stage cannot accept; hold IF/ID.
redirect_i  in  1  branch/jump taken; flush and refetch.
redirect_pc_i  in  ADDR_W  redirect target.
halt_i  in  1  syscall-exit seen in ID; stop fetching.
id_valid  out  1  IF/ID register holds a live instruction.
id_pc  out  ADDR_W  PC of the instruction in IF/ID.
id_instr  out  32  instruction in IF/ID.
id_pc_plus4  out  ADDR_W  id_pc+4.
halted  out  1  fetch permanently stopped.

Behaviour:
- Reset (rst=0, async): pc=PC_RESET; state=IDLE; discard=0; id_valid=0; id_pc=0; id_instr=0; id_pc_plus4=0; halted=0; imem_req=0 while rst=0.
- Fetch FSM states:
  - IDLE: imem_req=1, imem_addr=pc (combinational from state/pc). Next state WAIT.
  - WAIT: wait for imem_rvalid.
  - HOLD: response captured in a one-entry pending buffer, waiting for ID to accept.
  - HALTED.
- At most one outstanding request.
- WAIT with imem_rvalid=1:
  - discard=1: drop the data, clear discard, go IDLE.
  - IF/ID can accept (id_valid=0 or stall_i=0): load id_instr=imem_rdata, id_pc=pc, id_pc_plus4=pc+4, id_valid=1; pc<=pc+4; go IDLE.
  - Otherwise: store the word in the pending buffer, go HOLD.
- HOLD and stall_i=0: move the pending word into IF/ID (id_valid=1); pc<=pc+4; go IDLE.
- IF/ID hold: stall_i=1 and id_valid=1 keep all id_* outputs unchanged.
- Bubble: stall_i=0 with no new load in that cycle sets id_valid<=0.
- Redirect (redirect_i=1) has priority over stall and normal fetch, and applies in the same edge:
  - pc<=redirect_pc_i with bits [1:0] forced to 0.
  - id_valid<=0 (flush); pending buffer dropped.
  - State WAIT: set discard=1 and stay WAIT. Exception: if imem_rvalid=1 in that same cycle, drop that response, keep discard=0, and go IDLE.
  - State IDLE or HOLD: go IDLE. The request pulsed by IDLE in that cycle is treated as outstanding, so go WAIT with discard=1.
- Halt (halt_i=1) has priority over redirect:
  - id_valid<=0; stop issuing requests.
  - If a request is outstanding, discard its response, then enter HALTED.
  - In HALTED: halted=1, imem_req=0, redirect_i/stall_i ignored. Only reset exits.
- Arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- Throughput: one instruction per 2 cycles at 1-cycle memory latency (IDLE→WAIT). Added latency adds wait cycles.

Test Plan:
- Release reset, 1-cycle memory, no stall → requests at 0x3000, 0x3004, 0x3008. id_pc follows the same sequence, id_valid=1 on each load edge.
- Load IF/ID, assert stall_i for 4 cycles while the next response returns → id_* unchanged, state HOLD, no new imem_req. Release stall → pending word appears next edge, pc advances by 4.
- redirect_i with redirect_pc_i=0x3043 while a 3-cycle response is outstanding → id_valid=0 next edge, stale response dropped, next imem_addr=0x3040.
- redirect_i and imem_rvalid in the same cycle → response dropped, next request at the target, no discard of the following response.
- halt_i with request outstanding → response discarded, halted=1, imem_req stays 0 for 20 cycles despite redirect_i pulses.
- Pull rst low mid-WAIT → all outputs at reset values immediately. After release, fetch restarts at 0x3000. A late imem_rvalid arriving during reset is ignored.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight
// and fills the IF/ID register, honouring ID stall, EX redirect and syscall halt.
module if_fetch_stage #(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  PC_RESET = ADDR_W'(32'h0000_3000)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic              halt_i,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [31:0]       id_instr,
   output logic [ADDR_W-1:0] id_pc_plus4,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD,
      S_DRAIN,
      S_HALTED
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic              discard_q;
   logic [31:0]       pend_q;
   logic              id_valid_q;
   logic [ADDR_W-1:0] id_pc_q;
   logic [31:0]       id_instr_q;
   logic [ADDR_W-1:0] id_pc_plus4_q;

   logic [ADDR_W-1:0] pc_plus4_d;
   logic [ADDR_W-1:0] redir_pc_d;
   logic              accept_d;
   logic              load_d;
   logic [31:0]       load_word_d;
   logic              outstanding_d;

   always_comb begin
      pc_plus4_d    = pc_q + ADDR_W'(4);
      redir_pc_d    = redirect_pc_i & ~ADDR_W'(3);
      accept_d      = !id_valid_q || !stall_i;
      load_d        = 1'b0;
      load_word_d   = imem_rdata;
      // A request is in flight after this edge if IDLE just pulsed one, or WAIT is still waiting.
      outstanding_d = (state_q == S_IDLE) || ((state_q == S_WAIT) && !imem_rvalid);
      if (!halt_i && !redirect_i) begin
         if ((state_q == S_WAIT) && imem_rvalid && !discard_q && accept_d) begin
            load_d = 1'b1;
         end else if ((state_q == S_HOLD) && !stall_i) begin
            load_d      = 1'b1;
            load_word_d = pend_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         pc_q          <= PC_RESET;
         discard_q     <= 1'b0;
         pend_q        <= '0;
         id_valid_q    <= 1'b0;
         id_pc_q       <= '0;
         id_instr_q    <= '0;
         id_pc_plus4_q <= '0;
      end else begin
         case (state_q)
            S_HALTED: ;
            S_DRAIN: begin
               if (imem_rvalid) begin
                  state_q <= S_HALTED;
               end
            end
            default: begin
               if (halt_i) begin
                  id_valid_q <= 1'b0;
                  discard_q  <= 1'b0;
                  state_q    <= outstanding_d ? S_DRAIN : S_HALTED;
               end else if (redirect_i) begin
                  pc_q       <= redir_pc_d;
                  id_valid_q <= 1'b0;
                  if (outstanding_d) begin
                     discard_q <= 1'b1;
                     state_q   <= S_WAIT;
                  end else begin
                     discard_q <= 1'b0;
                     state_q   <= S_IDLE;
                  end
               end else begin
                  if (!stall_i) begin
                     id_valid_q <= 1'b0;
                  end
                  if (load_d) begin
                     id_valid_q    <= 1'b1;
                     id_pc_q       <= pc_q;
                     id_instr_q    <= load_word_d;
                     id_pc_plus4_q <= pc_plus4_d;
                     pc_q          <= pc_plus4_d;
                     state_q       <= S_IDLE;
                  end else begin
                     case (state_q)
                        S_IDLE: state_q <= S_WAIT;
                        S_WAIT: begin
                           if (imem_rvalid) begin
                              if (discard_q) begin
                                 discard_q <= 1'b0;
                                 state_q   <= S_IDLE;
                              end else begin
                                 pend_q  <= imem_rdata;
                                 state_q <= S_HOLD;
                              end
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign imem_req    = rst && (state_q == S_IDLE);
   assign imem_addr   = pc_q;
   assign id_valid    = id_valid_q;
   assign id_pc       = id_pc_q;
   assign id_instr    = id_instr_q;
   assign id_pc_plus4 = id_pc_plus4_q;
   assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a latency-programmable memory model answers
// requests; expected fetch addresses and IF/ID loads are queued and popped on output.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        halt_i;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus4;
   logic        halted;

   if_fetch_stage #(.ADDR_W(32), .PC_RESET(32'h0000_3000)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .halt_i       (halt_i),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_instr     (id_instr),
      .id_pc_plus4  (id_pc_plus4),
      .halted       (halted)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   int          lat = 1;
   bit          strict_req = 1'b0;
   bit          prev_valid = 1'b0;
   logic [31:0] exp_req_q[$];
   logic [31:0] exp_ld_q[$];
   logic [31:0] mon_e;
   int          mcnt = 0;
   logic [31:0] maddr = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while ((exp_req_q.size() != 0 || exp_ld_q.size() != 0) && n < budget) begin
         cyc();
         n++;
      end
      check("pending_req", exp_req_q.size(), 0);
      check("pending_load", exp_ld_q.size(), 0);
      exp_req_q.delete();
      exp_ld_q.delete();
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      halt_i        = 1'b0;
      strict_req    = 1'b0;
      exp_req_q.delete();
      exp_ld_q.delete();
      repeat (5) cyc();
      // Release just after an edge so the first IDLE request spans a full cycle.
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Memory: samples a request mid-cycle, answers lat cycles later for one cycle.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (imem_req) begin
            mcnt  = lat;
            maddr = imem_addr;
         end
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mword(maddr);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         prev_valid = 1'b0;
         check("req_in_reset", imem_req, 0);
      end else begin
         if (imem_req) begin
            if (exp_req_q.size() > 0) begin
               mon_e = exp_req_q.pop_front();
               check("req_addr", imem_addr, mon_e);
            end else if (strict_req) begin
               check("spurious_req", imem_req, 0);
            end
         end
         if (id_valid && (!prev_valid || !stall_i)) begin
            if (exp_ld_q.size() > 0) begin
               mon_e = exp_ld_q.pop_front();
               check("load_pc", id_pc, mon_e);
               check("load_instr", id_instr, mword(mon_e));
               check("load_pc4", id_pc_plus4, mon_e + 32'd4);
            end else begin
               check("spurious_load", id_valid, 0);
            end
         end
         prev_valid = id_valid;
      end
   end

   initial begin
      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;
      #1 rst = 1'b0;
      #1;
      check("rst_req", imem_req, 0);
      check("rst_valid", id_valid, 0);
      check("rst_pc", id_pc, 0);
      check("rst_instr", id_instr, 0);
      check("rst_pc4", id_pc_plus4, 0);
      check("rst_halted", halted, 0);

      // Streaming fetch, 1-cycle memory
      lat = 1;
      do_reset();
      exp_req_q = '{32'h3000, 32'h3004, 32'h3008};
      exp_ld_q  = '{32'h3000, 32'h3004, 32'h3008};
      wait_empty(20);

      // Stall while next response returns, then release
      lat = 2;
      do_reset();
      exp_req_q = '{32'h3000, 32'h3004};
      exp_ld_q  = '{32'h3000};
      wait_empty(20);
      stall_i    = 1'b1;
      strict_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("stall_valid", id_valid, 1);
         check("stall_pc", id_pc, 32'h3000);
         check("stall_instr", id_instr, mword(32'h3000));
      end
      exp_ld_q.push_back(32'h3004);
      exp_req_q.push_back(32'h3008);
      strict_req = 1'b0;
      stall_i    = 1'b0;
      cyc();
      check("release_pc", id_pc, 32'h3004);
      wait_empty(10);

      // Redirect while a 3-cycle response is outstanding
      lat = 3;
      do_reset();
      exp_req_q = '{32'h3000, 32'h3004};
      exp_ld_q  = '{32'h3000};
      wait_empty(20);
      stall_i = 1'b1;
      cyc();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h3043;
      exp_req_q.push_back(32'h3040);
      exp_ld_q.push_back(32'h3040);
      cyc();
      check("redir_flush", id_valid, 0);
      redirect_i = 1'b0;
      stall_i    = 1'b0;
      wait_empty(20);

      // Redirect coincident with the response
      lat = 1;
      do_reset();
      exp_req_q = '{32'h3000, 32'h3004};
      exp_ld_q  = '{32'h3000};
      wait_empty(20);
      cyc();
      check("coinc_rvalid", imem_rvalid, 1);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h3100;
      exp_req_q.push_back(32'h3100);
      exp_req_q.push_back(32'h3104);
      exp_ld_q.push_back(32'h3100);
      cyc();
      redirect_i = 1'b0;
      wait_empty(20);

      // Redirect from IDLE to the top of the address space; PC wraps to 0
      lat = 1;
      do_reset();
      exp_req_q = '{32'h3000};
      wait_empty(10);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFF;
      exp_req_q.push_back(32'hFFFF_FFFC);
      exp_req_q.push_back(32'h0000_0000);
      exp_ld_q.push_back(32'hFFFF_FFFC);
      cyc();
      redirect_i = 1'b0;
      wait_empty(20);

      // Halt with a request outstanding
      lat = 3;
      do_reset();
      exp_req_q = '{32'h3000};
      wait_empty(10);
      cyc();
      halt_i = 1'b1;
      cyc();
      halt_i     = 1'b0;
      strict_req = 1'b1;
      check("halt_flush", id_valid, 0);
      check("halt_draining", halted, 0);
      for (int i = 0; i < 10 && !halted; i++) cyc();
      check("halted", halted, 1);
      for (int i = 0; i < 20; i++) begin
         redirect_i    = i[0];
         redirect_pc_i = 32'h4000;
         stall_i       = i[1];
         cyc();
      end
      redirect_i = 1'b0;
      stall_i    = 1'b0;
      check("halted_stays", halted, 1);
      check("halted_valid", id_valid, 0);

      // Reset mid-WAIT with a live IF/ID entry; late response lands during reset
      lat = 3;
      do_reset();
      exp_req_q = '{32'h3000, 32'h3004};
      exp_ld_q  = '{32'h3000};
      wait_empty(20);
      stall_i = 1'b1;
      cyc();
      check("pre_rst_valid", id_valid, 1);
      rst = 1'b0;
      #1;
      check("mid_rst_req", imem_req, 0);
      check("mid_rst_valid", id_valid, 0);
      check("mid_rst_pc", id_pc, 0);
      check("mid_rst_instr", id_instr, 0);
      check("mid_rst_pc4", id_pc_plus4, 0);
      check("mid_rst_halted", halted, 0);
      stall_i    = 1'b0;
      strict_req = 1'b1;
      repeat (4) cyc();
      exp_req_q = '{32'h3000, 32'h3004};
      exp_ld_q  = '{32'h3000};
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_empty(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
